rv32_ifetch_v2: RTL and testbench
=================================

# rv32_ifetch_v2

Instruction fetch stage sitting directly downstream of the PC unit and upstream of decode. Takes the current fetch address, issues it to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small queue feeding the IF/ID boundary. Drives `busy` back to the PC unit so the PC only advances when its address has been accepted, and honours branch `flush` by discarding queued and in-flight fetches.

## Interface
- `DEPTH`, 2: instruction queue entries; power of two, ≥2.
- `NOP`, 32'h0000_0013: instruction word presented when the queue is empty (`addi x0,x0,0`).

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  in  32  fetch address from the PC unit.
- `flush`  in  1  branch redirect; kill queue contents and any in-flight fetch.
- `stall`  in  1  decode hold; head entry is not consumed.
- `busy`  out  1  to PC unit; low only in a cycle where the fetch of `pc` is accepted.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  response instruction word.
- `id_valid`  out  1  queue head is valid.
- `id_instr`  out  32  head instruction; `NOP` when `id_valid` low.
- `id_pc`  out  32  head PC; 0 when `id_valid` low.

## Operation
- FSM states: IDLE (nothing outstanding), WAIT (one request granted, response pending), DROP (flushed while pending; next response discarded).
- At most one outstanding request. `accept = imem_req & imem_gnt`; on accept latch `req_pc <= pc`, go to WAIT.
- `imem_req = ~flush & (IDLE | (WAIT & imem_rvalid)) & room`, where `room` = queue occupancy after this cycle's push/pop < `DEPTH`.
- `busy = ~accept` (combinational).
- WAIT & `imem_rvalid`: push `{req_pc, imem_rdata}`; next state WAIT if a new request is accepted the same cycle, else IDLE.
- Pop when `id_valid & ~stall`. Push and pop in the same cycle: occupancy unchanged, head advances.
- `flush`: occupancy → 0, pointers reset; no push that cycle; `imem_req` low. If WAIT without `imem_rvalid` → DROP; WAIT with `imem_rvalid` → data discarded, IDLE; IDLE → IDLE.
- DROP: `imem_req` low; on `imem_rvalid` discard data, → IDLE. Flush in DROP stays in DROP.
- Push into a full queue is unreachable; bench asserts it.
- Reset values: state IDLE, occupancy 0, pointers 0, `req_pc` 0, `id_valid` 0, `id_instr` = `NOP`, `id_pc` 0, `imem_req` 0 during reset, `busy` 1.

## Timing
- Grant at cycle N: `imem_rvalid` earliest N+1; entry visible on `id_*` at N+2 (queue registered).
- Sustained throughput 1 instruction/cycle when memory responds every cycle after grant and decode not stalled.
- `flush` at cycle N: `id_valid` low from N+1; first new request issued at N+1 if IDLE, else after the dropped response.
- `busy`, `imem_req` are combinational from state, occupancy, `imem_gnt`, `imem_rvalid`, `flush`, `stall`; no combinational path from `imem_rdata`.
- Reset asserted mid-fetch: immediate return to reset values; stale response after reset release is not expected (memory reset together).

## Structure
- Package `rv32_ifetch_pkg`: state enum `ifetch_state_t` {IDLE, WAIT, DROP}, `NOP` localparam, struct `fetch_entry_t` {pc[31:0], instr[31:0]}.
- Sub-module `rv32_ifq`: synchronous FIFO of `fetch_entry_t`, `DEPTH` entries, push/pop/clear, occupancy count, full/empty; clear has priority over push.

## Test plan
- Reset, then `pc`=0x0, memory grants same cycle, responds next cycle with 0x00500093 -> `id_valid` at N+2, `id_pc`=0x0, `id_instr`=0x00500093; `busy` low at N only.
- Back-to-back fetch 0x0,0x4,0x8,0xC with 1-cycle memory, no stall -> four consecutive `id_valid` cycles, PCs in order, no bubbles.
- `stall` held high with DEPTH=2 -> after two entries `imem_req` drops, `busy` stays high, `pc` unchanged; release stall -> entries drain in order, fetch resumes.
- `flush` in WAIT, response 0xDEADBEEF arrives next cycle, `pc` redirected to 0x40 -> 0xDEADBEEF never appears on `id_instr`; first valid entry has `id_pc`=0x40.
- `flush` in same cycle as `imem_rvalid` and a pop -> queue empty next cycle, state IDLE, `id_instr`=0x00000013.
- `imem_gnt` withheld 3 cycles -> `imem_req` held high, `imem_addr` stable, `busy` high throughout; `rst_n` dropped mid-WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/rv32_ifetch_pkg.sv
// Shared types for the RV32 instruction fetch stage.
package rv32_ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_ifq.sv
// Small synchronous FIFO of fetched {pc, instr} entries; clear overrides push.
module rv32_ifq
  import rv32_ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/rv32_ifetch_v2.sv
// Fetch stage: one outstanding imem request, responses queued with their PCs
// toward decode; flush kills queued entries and drops any in-flight response.
module rv32_ifetch_v2 #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = rv32_ifetch_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        stall,
  output logic        busy,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  import rv32_ifetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_t state_reg, state_next;
  logic [31:0]   req_pc_reg;
  logic          accept, push, pop, room;
  logic [CW-1:0] q_count;
  logic [CW:0]   count_after;
  logic          q_full, q_empty;
  fetch_entry_t  q_din, q_head;

  assign pop         = !q_empty && !stall;
  assign push        = (state_reg == WAIT) && imem_rvalid && !flush;
  assign count_after = {1'b0, q_count} + (CW+1)'(push) - (CW+1)'(pop);
  // Only ask for a new word when its response is guaranteed a free slot.
  assign room        = count_after < (CW+1)'(DEPTH);

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        imem_req = !flush && room;
        if (imem_req && imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        imem_req = !flush && imem_rvalid && room;
        if (flush)            state_next = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_next = (imem_req && imem_gnt) ? WAIT : IDLE;
      end
      DROP: begin
        if (imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    imem_req = imem_req && rst_n;
  end

  assign accept    = imem_req && imem_gnt;
  assign busy      = !accept;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      req_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) req_pc_reg <= pc;
    end
  end

  assign q_din.pc    = req_pc_reg;
  assign q_din.instr = imem_rdata;

  rv32_ifq #(.DEPTH(DEPTH)) u_ifq (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign id_valid = !q_empty;
  assign id_instr = q_empty ? NOP : q_head.instr;
  assign id_pc    = q_empty ? 32'h0 : q_head.pc;

endmodule

// File: tb/tb_rv32_ifetch_v2.sv
// Directed bench for rv32_ifetch_v2 with hand-computed expectations.
module tb_rv32_ifetch_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        flush, stall;
  logic        busy, imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;

  int n_assert = 0;
  int n_fail   = 0;

  rv32_ifetch_v2 #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pushing into a full queue must never happen.
  always @(negedge clk) begin
    if (rst_n) begin
      n_assert++;
      assert (!(dut.push && dut.q_full)) else begin
        n_fail++;
        $error("FAIL push_full: observed push=1 full=1 expected never");
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc = 32'h0; flush = 1'b0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #2;
    check("rst_req", imem_req, 0);
    check("rst_busy", busy, 1);
    check("rst_valid", id_valid, 0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", id_pc, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Single fetch: grant at N, response N+1, visible N+2
    pc = 32'h0; imem_gnt = 1'b1; #1;
    check("s1_req_N", imem_req, 1);
    check("s1_addr_N", imem_addr, 32'h0);
    check("s1_busy_N", busy, 0);
    cyc();
    pc = 32'h4; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
    check("s1_busy_N1", busy, 1);
    check("s1_valid_N1", id_valid, 0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check("s1_valid_N2", id_valid, 1);
    check("s1_pc_N2", id_pc, 32'h0);
    check("s1_instr_N2", id_instr, 32'h0050_0093);
    check("s1_busy_N2", busy, 1);
    cyc();
    $display("txn single fetch done");
    check("s1_drain", id_valid, 0);

    // Back-to-back 0x0,0x4,0x8,0xC; data = 0x1000_0000 + pc
    pc = 32'h0; imem_gnt = 1'b1; #1;
    check("b2b_busy0", busy, 0);
    cyc();
    for (int k = 1; k <= 5; k++) begin
      pc = 32'(4 * k);
      imem_gnt    = (k <= 3);
      imem_rvalid = (k <= 4);
      imem_rdata  = 32'h1000_0000 + 32'(4 * (k - 1));
      #1;
      if (k >= 2) begin
        check("b2b_valid", id_valid, 1);
        check("b2b_pc", id_pc, 32'(4 * (k - 2)));
        check("b2b_instr", id_instr, 32'h1000_0000 + 32'(4 * (k - 2)));
      end
      if (k <= 3) check("b2b_busy", busy, 0);
      cyc();
      if (k >= 2) $display("txn b2b pc=%h", 32'(4 * (k - 2)));
    end
    imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
    check("b2b_empty", id_valid, 0);

    // Stall fills the 2-deep queue, then drains in order
    stall = 1'b1; pc = 32'h20; imem_gnt = 1'b1; #1;
    check("st_busy0", busy, 0);
    cyc();
    pc = 32'h24; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0020; #1;
    check("st_busy1", busy, 0);
    cyc();
    pc = 32'h28; imem_rdata = 32'h1000_0024; #1;
    check("st_req_full", imem_req, 0);
    check("st_busy_full", busy, 1);
    cyc();
    imem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("st_req_hold", imem_req, 0);
      check("st_busy_hold", busy, 1);
      check("st_head", id_pc, 32'h20);
      cyc();
    end
    stall = 1'b0; #1;
    check("st_resume_busy", busy, 0);
    check("st_drain0", id_pc, 32'h20);
    check("st_drain0_i", id_instr, 32'h1000_0020);
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0028; #1;
    check("st_drain1", id_pc, 32'h24);
    cyc();
    imem_rvalid = 1'b0; #1;
    check("st_drain2", id_pc, 32'h28);
    check("st_drain2_i", id_instr, 32'h1000_0028);
    cyc();
    $display("txn stall drain done");
    check("st_empty", id_valid, 0);

    // Flush while WAIT; dropped 0xDEADBEEF must never reach decode
    pc = 32'h30; imem_gnt = 1'b1; #1;
    check("fl_busy0", busy, 0);
    cyc();
    flush = 1'b1; #1;
    check("fl_req", imem_req, 0);
    check("fl_busy", busy, 1);
    cyc();
    flush = 1'b0; pc = 32'h40; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("fl_drop_req", imem_req, 0);
    check("fl_drop_valid", id_valid, 0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check("fl_no_beef", id_instr, 32'h0000_0013);
    check("fl_new_busy", busy, 0);
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0040; #1;
    check("fl_valid_wait", id_valid, 0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check("fl_first_pc", id_pc, 32'h40);
    check("fl_first_instr", id_instr, 32'h1000_0040);
    cyc();
    $display("txn flush redirect pc=40");

    // Flush coinciding with a response and a pop
    pc = 32'h50; imem_gnt = 1'b1; #1;
    cyc();
    pc = 32'h54; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0050; #1;
    cyc();
    flush = 1'b1; imem_rdata = 32'h1000_0054; #1;
    check("fr_head", id_pc, 32'h50);
    check("fr_req", imem_req, 0);
    cyc();
    flush = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
    check("fr_valid", id_valid, 0);
    check("fr_instr", id_instr, 32'h0000_0013);
    check("fr_pc", id_pc, 0);
    check("fr_idle_req", imem_req, 1);
    $display("txn flush+rvalid+pop done");

    // Grant withheld three cycles
    pc = 32'h60;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("gw_req", imem_req, 1);
      check("gw_addr", imem_addr, 32'h60);
      check("gw_busy", busy, 1);
      cyc();
    end
    imem_gnt = 1'b1; #1;
    check("gw_accept", busy, 0);
    cyc();
    stall = 1'b1; pc = 32'h64; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0060; #1;
    cyc();
    imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
    check("ar_pre_valid", id_valid, 1);
    check("ar_pre_pc", id_pc, 32'h60);
    rst_n = 1'b0; #1;
    check("ar_valid", id_valid, 0);
    check("ar_instr", id_instr, 32'h0000_0013);
    check("ar_pc", id_pc, 0);
    check("ar_req", imem_req, 0);
    check("ar_busy", busy, 1);
    cyc();
    rst_n = 1'b1; stall = 1'b0; #1;
    check("ar_post_req", imem_req, 1);
    check("ar_post_valid", id_valid, 0);
    $display("txn async reset done");
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
